// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// dds_pkg : shared encodings for the multi-voice DDS sequencer
// Revision: 1.0
// ============================================================================
package dds_pkg;

  typedef enum logic [2:0] {
    WAVE_SAW    = 3'd0,
    WAVE_SQUARE = 3'd1,
    WAVE_TRI    = 3'd2,
    WAVE_PULSE  = 3'd3
  } wave_sel_e;

  typedef enum logic [1:0] {
    REG_TUNE      = 2'd0,
    REG_CTRL      = 2'd1,
    REG_PW        = 2'd2,
    REG_PHASE_CLR = 2'd3
  } cfg_reg_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  localparam int c_CTRL_SEL_LSB = 0;
  localparam int c_CTRL_SEL_W   = 3;
  localparam int c_CTRL_EN_BIT  = 3;

endpackage
`default_nettype wire

// File: rtl/dds_wave_gen.sv
`default_nettype none
// ============================================================================
// dds_wave_gen : combinational phase-to-amplitude shaper for one voice
// Revision: 1.0
// ============================================================================
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int WAVE_W  = 12
) (
  input  logic [PHASE_W-1:0] phase,
  input  logic [2:0]         wave_sel,
  input  logic [WAVE_W-1:0]  pw,
  output logic [WAVE_W-1:0]  w
);

  logic [WAVE_W-1:0]          w_top;
  logic                       w_msb;
  logic [WAVE_W-2:0]          w_tri_t;
  logic [PHASE_W-WAVE_W-1:0]  w_unused_phase_lsbs;

  assign w_top               = phase[PHASE_W-1 -: WAVE_W];
  assign w_msb               = phase[PHASE_W-1];
  assign w_tri_t             = phase[PHASE_W-2 -: WAVE_W-1];
  assign w_unused_phase_lsbs = phase[PHASE_W-WAVE_W-1:0];

  always_comb begin
    w = '0;
    case (wave_sel)
      WAVE_SAW:    w = w_top;
      WAVE_SQUARE: w = {WAVE_W{w_msb}};
      // falling half mirrors the rising half of the ramp
      WAVE_TRI:    w = w_msb ? {~w_tri_t, 1'b0} : {w_tri_t, 1'b0};
      WAVE_PULSE:  w = (w_top < pw) ? '1 : '0;
      default:     w = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dds_voice_sequencer.sv
`default_nettype none
// ============================================================================
// dds_voice_sequencer : time-multiplexed DDS engine mixing VOICES voices
// Revision: 1.0
// ============================================================================
module dds_voice_sequencer
  import dds_pkg::*;
#(
  parameter int VOICES     = 4,
  parameter int TUNE_W     = 16,
  parameter int PHASE_W    = 16,
  parameter int WAVE_W     = 12,
  parameter int CFG_DATA_W = 16,
  parameter int VIDX_W     = $clog2(VOICES),
  parameter int SUM_W      = WAVE_W + VIDX_W
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  cfg_we,
  input  logic [VIDX_W-1:0]     cfg_voice,
  input  logic [1:0]            cfg_reg,
  input  logic [CFG_DATA_W-1:0] cfg_data,
  output logic [SUM_W-1:0]      sample,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  logic [PHASE_W-1:0] r_phase    [VOICES];
  logic [TUNE_W-1:0]  r_tune     [VOICES];
  logic [2:0]         r_wave_sel [VOICES];
  logic [WAVE_W-1:0]  r_pw       [VOICES];
  logic [VOICES-1:0]  r_enable;

  state_e             r_state, w_state_nxt;
  logic [VIDX_W-1:0]  r_vidx;
  logic [SUM_W-1:0]   r_acc;
  logic [SUM_W-1:0]   r_sample;
  logic               r_sample_valid;
  logic               r_overrun;

  logic [WAVE_W-1:0]  w_wave;
  logic [SUM_W-1:0]   w_acc_nxt;
  logic               w_last;

  dds_wave_gen #(
    .PHASE_W (PHASE_W),
    .WAVE_W  (WAVE_W)
  ) u_wave_gen (
    .phase    (r_phase[r_vidx]),
    .wave_sel (r_wave_sel[r_vidx]),
    .pw       (r_pw[r_vidx]),
    .w        (w_wave)
  );

  assign w_acc_nxt = r_enable[r_vidx] ? r_acc + SUM_W'(w_wave) : r_acc;
  assign w_last    = (r_vidx == VIDX_W'(VOICES - 1));

  // Config writes land after the accumulate so a same-cycle PHASE_CLR wins.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        r_phase[i]    <= '0;
        r_tune[i]     <= '0;
        r_wave_sel[i] <= '0;
        r_pw[i]       <= '0;
      end
      r_enable <= '0;
    end else begin
      if (r_state == ST_ACCUM && r_enable[r_vidx])
        r_phase[r_vidx] <= r_phase[r_vidx] + PHASE_W'(r_tune[r_vidx]);
      if (cfg_we) begin
        case (cfg_reg)
          REG_TUNE: r_tune[cfg_voice] <= cfg_data[TUNE_W-1:0];
          REG_CTRL: begin
            r_wave_sel[cfg_voice] <= cfg_data[c_CTRL_SEL_LSB +: c_CTRL_SEL_W];
            r_enable[cfg_voice]   <= cfg_data[c_CTRL_EN_BIT];
          end
          REG_PW:        r_pw[cfg_voice]    <= cfg_data[WAVE_W-1:0];
          REG_PHASE_CLR: r_phase[cfg_voice] <= '0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (tick)         w_state_nxt = ST_ACCUM;
      ST_ACCUM:  if (w_last)       w_state_nxt = ST_OUTPUT;
      ST_OUTPUT: if (sample_ready) w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_vidx         <= '0;
      r_acc          <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (tick) begin
          r_acc  <= '0;
          r_vidx <= '0;
        end
        ST_ACCUM: begin
          r_acc  <= w_acc_nxt;
          r_vidx <= r_vidx + 1'b1;
          if (w_last) begin
            r_sample       <= w_acc_nxt;
            r_sample_valid <= 1'b1;
          end
        end
        ST_OUTPUT: if (sample_ready) r_sample_valid <= 1'b0;
        default: ;
      endcase
      if (tick && r_state != ST_IDLE) r_overrun <= 1'b1;
      else if (overrun_clr)          r_overrun <= 1'b0;
    end
  end

  assign sample       = r_sample;
  assign sample_valid = r_sample_valid;
  assign busy         = (r_state != ST_IDLE);
  assign overrun      = r_overrun;

endmodule
`default_nettype wire
